// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU front-end blocks.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        FULL,
        FAULT
    } ifetch_state_t;

    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;
    localparam int         INSTR_W        = 32;

endpackage

// File: rtl/byte_swap32.sv
// Reverses the byte order of a 32-bit word (little-endian fabric to big-endian core).
module byte_swap32 (
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign data_out[8*gi +: 8] = data_in[8*(3-gi) +: 8];
    end

endmodule

// File: rtl/avalon_ifetch.sv
// Instruction fetch: one Avalon-MM read per PC value, one-entry buffer towards decode.
// Optional byte reversal of fetched words is enabled by defining IFETCH_ENDIAN_SWAP_EN.
module avalon_ifetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  instr_address,
    input  logic               flush,
    output logic               pc_advance,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    output logic [3:0]         avm_byteenable,
    input  logic               avm_waitrequest,
    input  logic [INSTR_W-1:0] avm_readdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    if (DATA_W != INSTR_W) begin : g_bad_data_w
        $error("avalon_ifetch: DATA_W must be 32");
    end

    ifetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [INSTR_W-1:0] fetch_data;

`ifdef IFETCH_ENDIAN_SWAP_EN
    byte_swap32 u_swap (
        .data_in  (avm_readdata),
        .data_out (fetch_data)
    );
`else
    assign fetch_data = avm_readdata;
`endif

    // The address is latched only in IDLE, so PC movement never disturbs an open read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE)
                addr_reg <= instr_address;
            if (pc_advance)
                instr_reg <= fetch_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_advance = 1'b0;
        case (state_reg)
            IDLE: begin
                if (instr_address[1:0] != 2'b00)
                    state_next = FAULT;
                else
                    state_next = FETCH;
            end
            FETCH: begin
                if (!avm_waitrequest) begin
                    if (!flush) begin
                        pc_advance = 1'b1;
                        state_next = FULL;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (flush) begin
                    // A stalled read cannot be withdrawn; finish it and discard the data.
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!avm_waitrequest)
                    state_next = IDLE;
            end
            FULL: begin
                if (flush || instr_ready)
                    state_next = IDLE;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign avm_read       = (state_reg == FETCH) || (state_reg == DRAIN);
    assign avm_address    = addr_reg;
    assign avm_byteenable = BYTEENABLE_ALL;
    assign instr          = instr_reg;
    assign instr_valid    = (state_reg == FULL);
    assign fetch_fault    = (state_reg == FAULT);

endmodule

// File: tb/tb_avalon_ifetch.sv
// Self-checking bench for avalon_ifetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_avalon_ifetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_address = 32'h0;
    logic        flush = 1'b0;
    logic        pc_advance;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fetch_fault;

    avalon_ifetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_address   (instr_address),
        .flush           (flush),
        .pc_advance      (pc_advance),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

`ifdef IFETCH_ENDIAN_SWAP_EN
    localparam logic [31:0] ENDIAN_EXPECT = 32'h12345678;
`else
    localparam logic [31:0] ENDIAN_EXPECT = 32'h78563412;
`endif

    int checks = 0;
    int errors = 0;

    // Transaction-level model: an open read, a buffered instruction, or a latched fault.
    logic        m_read, m_valid, m_fault, txn_flushed;
    logic [31:0] m_addr, m_instr;
    logic [31:0] pc;
    logic        prev_fl, prev_adv;
    logic [31:0] prev_tgt;
    logic        prev_read_obs;
    logic [31:0] starts[$];
    int          adv_count = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200)
            return 32'h78563412;
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
`ifdef IFETCH_ENDIAN_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] new_pc);
        reset = 1'b0;
        flush = 1'b0;
        instr_ready = 1'b0;
        avm_waitrequest = 1'b0;
        #1;
        chk("rst_read", {31'd0, avm_read}, 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_adv", {31'd0, pc_advance}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_be", {28'd0, avm_byteenable}, 32'hF);
        m_read = 0; m_valid = 0; m_fault = 0; txn_flushed = 0;
        m_addr = 0; m_instr = 0;
        prev_fl = 0; prev_adv = 0; prev_tgt = 0; prev_read_obs = 0;
        pc = new_pc;
        instr_address = pc;
        @(negedge clk);
    endtask

    task automatic cycle(input logic wr, input logic fl, input logic rdy, input logic [31:0] tgt);
        logic exp_adv;
        @(posedge clk);
        #1;
        if (prev_fl)
            pc = prev_tgt;
        else if (prev_adv)
            pc = pc + 32'd4;
        reset = 1'b1;
        instr_address = pc;
        avm_waitrequest = wr;
        flush = fl;
        instr_ready = rdy;
        #1;
        avm_readdata = avm_read ? mem_word(avm_address) : $urandom;
        @(negedge clk);
        exp_adv = m_read && !wr && !txn_flushed && !fl;
        chk("read", {31'd0, avm_read}, {31'd0, m_read});
        chk("valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("adv", {31'd0, pc_advance}, {31'd0, exp_adv});
        if (m_read)
            chk("addr", avm_address, m_addr);
        if (m_valid)
            chk("instr", instr, m_instr);
        $display("t=%0t pc=%h wr=%0b fl=%0b rdy=%0b read=%0b addr=%h adv=%0b valid=%0b instr=%h fault=%0b",
                 $time, pc, wr, fl, rdy, avm_read, avm_address, pc_advance, instr_valid, instr, fetch_fault);
        if (avm_read && !prev_read_obs)
            starts.push_back(avm_address);
        if (pc_advance)
            adv_count++;
        prev_read_obs = avm_read;
        prev_adv = pc_advance;
        prev_fl = fl;
        prev_tgt = tgt;
        if (m_fault) begin
        end else if (m_read) begin
            if (!wr) begin
                if (!txn_flushed && !fl) begin
                    m_valid = 1;
                    m_instr = exp_data(m_addr);
                end
                m_read = 0;
                txn_flushed = 0;
            end else if (fl) begin
                txn_flushed = 1;
            end
        end else if (m_valid) begin
            if (fl || rdy)
                m_valid = 0;
        end else begin
            m_addr = pc;
            if (pc[1:0] != 2'b00)
                m_fault = 1;
            else
                m_read = 1;
        end
    endtask

    initial begin
        int adv_before;
        logic [31:0] held;

        do_reset(32'hBFC0_0000);

        // Zero-wait slave, decode always ready: two back-to-back instructions.
        repeat (7) cycle(0, 0, 1, 0);
        chk("n_starts", starts.size(), 32'd2);
        if (starts.size() >= 2) begin
            chk("first_addr", starts[0], 32'hBFC0_0000);
            chk("second_addr", starts[1], 32'hBFC0_0004);
        end
        chk("adv_pair", adv_count, 32'd2);

        // Three wait states: read held, exactly one advance.
        adv_before = adv_count;
        repeat (3) cycle(1, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("stall_adv", adv_count - adv_before, 32'd1);

        // Decode stalls for five cycles, then flush and ready together.
        repeat (5) cycle(0, 0, 0, 0);
        held = instr;
        chk("hold_instr", held, exp_data(32'hBFC0_0008));
        chk("hold_starts", starts.size(), 32'd3);
        cycle(0, 1, 1, 32'h40);
        cycle(0, 0, 0, 0);
        chk("flush_ready_valid", {31'd0, instr_valid}, 32'd0);

        // Flush during a stalled read: read drains, no advance, next fetch at new PC.
        adv_before = adv_count;
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 32'h100);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("drain_adv", adv_count - adv_before, 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("redirect_addr", starts[$], 32'h100);

        // Endianness check on a known word.
        cycle(0, 1, 0, 32'h200);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("endian_addr", starts[$], 32'h200);
        cycle(0, 0, 0, 0);
        chk("endian_instr", instr, ENDIAN_EXPECT);
        cycle(0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 10) < 3, ($urandom % 20) == 0, ($urandom % 10) < 6,
                  $urandom & 32'hFFFF_FFFC);
        end

        // Reset in the middle of a stalled read drops the request immediately.
        for (int i = 0; i < 20 && !m_read; i++)
            cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);
        chk("pre_reset_read", {31'd0, avm_read}, 32'd1);
        do_reset(32'h0000_0002);

        // Misaligned PC: sticky fault, flush has no effect, only reset clears it.
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cycle($urandom % 2, 1, 1, 32'h300);
        chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        do_reset(32'h0000_0000);
        repeat (4) cycle(0, 0, 1, 0);
        chk("post_fault_addr", starts[$], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
